// File: rtl/stream_mux2_if.sv
// Valid/ready beat stream shared by both producers and the merged output.
// sel is only meaningful on the merged side; producers tie it low.
interface stream_mux2_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             sel;
  logic             ready;

  modport master (
    output valid, data, last, sel,
    input  ready
  );

  modport slave (
    input  valid, data, last, sel,
    output ready
  );
endinterface

// File: rtl/stream_mux2.sv
// Two-to-one packet merge with round-robin arbitration.
// A grant is held until the packet's last beat, so packets never interleave.
module stream_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  stream_mux2_if.slave  a,
  stream_mux2_if.slave  b,
  stream_mux2_if.master merged
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic             ptr_next;
  logic             grant_a;
  logic             grant_b;
  logic             free;
  logic             take_a;
  logic             take_b;
  logic [WIDTH-1:0] load_data;
  logic             load_last;

  // The output register can take a new beat when empty or being drained.
  assign free   = !merged.valid || merged.ready;
  assign take_a = a.valid && a.ready;
  assign take_b = b.valid && b.ready;

  // ptr remembers the last source to finish a packet; reset favours A.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b1;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (take_a) begin
      if (a.last) begin
        state_next = IDLE;
        ptr_next   = 1'b0;
      end else begin
        state_next = LOCK_A;
      end
    end else if (take_b) begin
      if (b.last) begin
        state_next = IDLE;
        ptr_next   = 1'b1;
      end else begin
        state_next = LOCK_B;
      end
    end
  end

  // A lock keeps its grant through gaps in the owner's valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (a.valid && b.valid) begin
          grant_a = ptr;
          grant_b = !ptr;
        end else begin
          grant_a = a.valid;
          grant_b = b.valid;
        end
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
    a.ready = free && grant_a && !rst;
    b.ready = free && grant_b && !rst;
  end

  assign load_data = take_b ? b.data : a.data;
  assign load_last = take_b ? b.last : a.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      merged.valid <= 1'b0;
      merged.data  <= '0;
      merged.last  <= 1'b0;
      merged.sel   <= 1'b0;
    end else if (take_a || take_b) begin
      merged.valid <= 1'b1;
      merged.data  <= load_data;
      merged.last  <= load_last;
      merged.sel   <= take_b;
    end else if (free) begin
      merged.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux2.sv
// Directed bench for stream_mux2: reset, round-robin ties, packet lock,
// backpressure and reset in the middle of a packet.
module tb_stream_mux2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stream_mux2_if #(.WIDTH(8)) a_if ();
  stream_mux2_if #(.WIDTH(8)) b_if ();
  stream_mux2_if #(.WIDTH(8)) m_if ();

  stream_mux2 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a_if),
    .b      (b_if),
    .merged (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check the combinational
  // readys, then check the registered output just after the rising edge.
  task automatic applyStimulus(
    input string tag,
    input logic r,
    input logic av, input logic [7:0] ad, input logic al,
    input logic bv, input logic [7:0] bd, input logic bl,
    input logic ordy,
    input logic ear, input logic ebr,
    input logic eov, input logic [7:0] eod, input logic eol, input logic eos
  );
    @(negedge clk);
    rst        = r;
    a_if.valid = av;
    a_if.data  = ad;
    a_if.last  = al;
    b_if.valid = bv;
    b_if.data  = bd;
    b_if.last  = bl;
    m_if.ready = ordy;
    #1;
    checkOutput({tag, " a_ready"}, 32'(a_if.ready), 32'(ear));
    checkOutput({tag, " b_ready"}, 32'(b_if.ready), 32'(ebr));
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid"}, 32'(m_if.valid), 32'(eov));
    if (eov || r) begin
      checkOutput({tag, " out_data"}, 32'(m_if.data), 32'(eod));
      checkOutput({tag, " out_last"}, 32'(m_if.last), 32'(eol));
      checkOutput({tag, " out_sel"}, 32'(m_if.sel), 32'(eos));
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    a_if.valid = 1'b0;
    a_if.data  = 8'h00;
    a_if.last  = 1'b0;
    a_if.sel   = 1'b0;
    b_if.valid = 1'b0;
    b_if.data  = 8'h00;
    b_if.last  = 1'b0;
    b_if.sel   = 1'b0;
    m_if.ready = 1'b1;

    //            tag     rst av  ad   al  bv  bd   bl  rdy ar  br  ov  od   ol  os
    applyStimulus("rst0", 1, 1, 8'h11, 1, 1, 8'h21, 1, 1, 0, 0, 0, 8'h00, 0, 0);
    applyStimulus("rst1", 1, 1, 8'h11, 1, 1, 8'h21, 1, 1, 0, 0, 0, 8'h00, 0, 0);

    // Ties alternate, starting with A right after reset.
    applyStimulus("rr0", 0, 1, 8'h11, 1, 1, 8'h21, 1, 1, 1, 0, 1, 8'h11, 1, 0);
    applyStimulus("rr1", 0, 1, 8'h12, 1, 1, 8'h21, 1, 1, 0, 1, 1, 8'h21, 1, 1);
    applyStimulus("rr2", 0, 1, 8'h12, 1, 1, 8'h22, 1, 1, 1, 0, 1, 8'h12, 1, 0);
    applyStimulus("rr3", 0, 1, 8'h13, 1, 1, 8'h22, 1, 1, 0, 1, 1, 8'h22, 1, 1);
    applyStimulus("rr4", 0, 1, 8'h13, 1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h13, 1, 0);
    applyStimulus("rr5", 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    // A holds its grant across a two-cycle valid gap while B waits.
    applyStimulus("lk0", 0, 1, 8'hA0, 0, 0, 8'h00, 0, 1, 1, 0, 1, 8'hA0, 0, 0);
    applyStimulus("lk1", 0, 1, 8'hA1, 0, 1, 8'h31, 1, 1, 1, 0, 1, 8'hA1, 0, 0);
    applyStimulus("lk2", 0, 0, 8'h00, 0, 1, 8'h31, 1, 1, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus("lk3", 0, 0, 8'h00, 0, 1, 8'h31, 1, 1, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus("lk4", 0, 1, 8'hA2, 0, 1, 8'h31, 1, 1, 1, 0, 1, 8'hA2, 0, 0);
    applyStimulus("lk5", 0, 1, 8'hA3, 1, 1, 8'h31, 1, 1, 1, 0, 1, 8'hA3, 1, 0);
    applyStimulus("lk6", 0, 0, 8'h00, 0, 1, 8'h31, 1, 1, 0, 1, 1, 8'h31, 1, 1);
    applyStimulus("lk7", 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    // Output stalled for five cycles; nothing may move or be lost.
    applyStimulus("bp0", 0, 1, 8'h41, 1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h41, 1, 0);
    applyStimulus("bp1", 0, 1, 8'h42, 1, 1, 8'h51, 1, 0, 0, 0, 1, 8'h41, 1, 0);
    applyStimulus("bp2", 0, 1, 8'h42, 1, 1, 8'h51, 1, 0, 0, 0, 1, 8'h41, 1, 0);
    applyStimulus("bp3", 0, 1, 8'h42, 1, 1, 8'h51, 1, 0, 0, 0, 1, 8'h41, 1, 0);
    applyStimulus("bp4", 0, 1, 8'h42, 1, 1, 8'h51, 1, 0, 0, 0, 1, 8'h41, 1, 0);
    applyStimulus("bp5", 0, 1, 8'h42, 1, 1, 8'h51, 1, 0, 0, 0, 1, 8'h41, 1, 0);
    applyStimulus("bp6", 0, 1, 8'h42, 1, 1, 8'h51, 1, 1, 0, 1, 1, 8'h51, 1, 1);
    applyStimulus("bp7", 0, 1, 8'h42, 1, 0, 8'h00, 0, 1, 1, 0, 1, 8'h42, 1, 0);
    applyStimulus("bp8", 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    // Reset lands on beat 2 of a B packet; A wins immediately afterwards.
    applyStimulus("mr0", 0, 0, 8'h00, 0, 1, 8'h61, 0, 1, 0, 1, 1, 8'h61, 0, 1);
    applyStimulus("mr1", 1, 1, 8'h71, 1, 1, 8'h62, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    applyStimulus("mr2", 0, 1, 8'h71, 1, 1, 8'h63, 0, 1, 1, 0, 1, 8'h71, 1, 0);
    applyStimulus("mr3", 0, 0, 8'h00, 0, 1, 8'h63, 0, 1, 0, 1, 1, 8'h63, 0, 1);
    applyStimulus("mr4", 0, 0, 8'h00, 0, 1, 8'h64, 1, 1, 0, 1, 1, 8'h64, 1, 1);
    applyStimulus("mr5", 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux2.md
# stream_mux2

Two-to-one packet multiplexer with valid/ready handshake: merges input streams A and B onto one registered output stream, SEL-equivalent choice made by round-robin arbitration. Once a packet is granted, the grant is held until its LAST beat transfers, so packets never interleave. It is the merge-side counterpart of the 1:2 demultiplexer and sits in front of any single-consumer datapath fed by two producers.

## Interface
- WIDTH, 8, data bits per beat
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- A_VALID  in  1  source A beat present
- A_DATA  in  WIDTH  source A data
- A_LAST  in  1  final beat of A packet
- A_READY  out  1  A beat accepted this cycle when A_VALID=1
- B_VALID, B_DATA, B_LAST, B_READY: as A, for source B
- OUT_VALID  out  1  output beat present (registered)
- OUT_DATA  out  WIDTH  output data (registered)
- OUT_LAST  out  1  final beat of packet (registered)
- OUT_SEL  out  1  source of current output beat: 0=A, 1=B (registered)
- OUT_READY  in  1  consumer accepts output beat

## Operation
- Output register "free" = !OUT_VALID || OUT_READY.
- States: IDLE, LOCK_A, LOCK_B. Priority pointer PTR = last source whose packet completed.
- Grant (combinational): IDLE: only A_VALID → A; only B_VALID → B; both → source != PTR; neither → none. LOCK_A → A. LOCK_B → B.
- A_READY = free && grant==A && !RST; B_READY likewise. Non-granted source READY=0.
- Input handshake (X_VALID && X_READY): load OUT_DATA/OUT_LAST from X, OUT_SEL=X, OUT_VALID=1.
- free with no input handshake: OUT_VALID=0 (OUT_DATA/LAST/SEL hold).
- !free: output register holds all fields; no input accepted.
- Transitions on accepted beat from X: LAST=0 → LOCK_X; LAST=1 → IDLE, PTR=X. No accepted beat → state unchanged (LOCK persists across gaps in X_VALID, regardless of other source).
- Single-beat packet (LAST=1 on first beat) in IDLE: stays IDLE, PTR updates.
- VALID must not depend on READY (sources); READY here may depend on VALIDs in IDLE.
- DATA/LAST of a source are sampled only on its handshake; values while VALID=0 are ignored.

## Timing
- Reset (RST=1 at edge): state=IDLE, PTR=B (A wins first tie), OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SEL=0. A_READY=B_READY=0 while RST=1.
- Reset mid-packet: lock and output beat discarded; next cycle after RST drops is IDLE with empty output.
- Latency: input handshake at edge N → OUT_VALID=1 with that beat after edge N.
- Throughput: one beat/cycle with OUT_READY held 1; no bubble at packet boundaries when the other source is waiting.
- Backpressure: OUT_READY=0 with OUT_VALID=1 → A_READY=B_READY=0 same cycle; output stable until accepted.
- Simultaneous output drain and input accept in same cycle is required (register replaced, not emptied).
- Both sources assert VALID with PTR=A → B granted; after B's LAST transfers, A granted next (if still valid).

## Test plan
- Reset: hold RST 2 cycles with A_VALID=B_VALID=1 → READYs 0, OUT_VALID=0, OUT_DATA=0; first post-reset grant is A.
- Tie round-robin: A sends 3 single-beat packets 0x11,0x12,0x13, B sends 0x21,0x22, OUT_READY=1 → output order 0x11,0x21,0x12,0x22,0x13, OUT_SEL 0,1,0,1,0, one beat/cycle.
- Packet lock: A sends 4-beat packet 0xA0..0xA3 with a 2-cycle VALID gap after beat 1, B valid throughout → B_READY=0 until 0xA3 transfers; B's beat follows the cycle after.
- Backpressure: OUT_READY=0 for 5 cycles mid-stream → OUT_DATA/LAST/SEL stable, both READYs 0, no beat lost or duplicated when OUT_READY returns.
- Reset mid-packet: RST during beat 2 of a 4-beat B packet → after release state IDLE, OUT_VALID=0, A (valid) granted immediately despite unfinished B packet.
- Random stress: random VALID/READY/LAST, WIDTH=8, 10k cycles → per-source beat order preserved, no packet interleaving on output, LAST counts match.
